// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP.
// It aligns the address and store data to 64-bit memory lanes and extracts and extends load results.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_misaligned
);
    localparam int unsigned XLEN  = 64;
    localparam int unsigned LANES = 8;
    localparam int unsigned OFFW  = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             lat_wen;
    logic             lat_signed;
    logic [1:0]       lat_size;
    logic [OFFW-1:0]  lat_off;
    logic             req_aligned;
    logic             accept;
    logic [LANES-1:0] req_mask;
    logic [XLEN-1:0]  load_shifted;
    logic [XLEN-1:0]  load_ext;

    // Natural alignment check and byte-enable pattern of the incoming request
    always_comb begin
        req_aligned = 1'b1;
        req_mask    = 8'h01;
        unique case (req_size)
            2'd0: begin req_aligned = 1'b1;                  req_mask = 8'h01; end
            2'd1: begin req_aligned = (req_addr[0] == 1'b0);   req_mask = 8'h03; end
            2'd2: begin req_aligned = (req_addr[1:0] == 2'b0); req_mask = 8'h0F; end
            default: begin req_aligned = (req_addr[2:0] == 3'b0); req_mask = 8'hFF; end
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (req_valid) state_next = req_aligned ? S_ACCESS : S_RESP;
            S_ACCESS: state_next = S_RESP;
            S_RESP:   if (resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Move the addressed lane down to bit 0, then truncate and extend
    always_comb begin
        load_shifted = mem_rdata >> {lat_off, 3'b000};
        load_ext     = load_shifted;
        unique case (lat_size)
            2'd0: load_ext = lat_signed ? XLEN'($signed(load_shifted[7:0]))  : XLEN'(load_shifted[7:0]);
            2'd1: load_ext = lat_signed ? XLEN'($signed(load_shifted[15:0])) : XLEN'(load_shifted[15:0]);
            2'd2: load_ext = lat_signed ? XLEN'($signed(load_shifted[31:0])) : XLEN'(load_shifted[31:0]);
            default: load_ext = load_shifted;
        endcase
    end

    // Strobes are armed only for the single cycle following an aligned accept
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            resp_rdata      <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_wmask       <= '0;
            mem_raddr       <= '0;
            mem_waddr       <= '0;
            mem_wdata       <= '0;
            lat_wen         <= 1'b0;
            lat_signed      <= 1'b0;
            lat_size        <= '0;
            lat_off         <= '0;
        end else begin
            req_ready  <= (state_next == S_IDLE);
            resp_valid <= (state_next == S_RESP);
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_wmask  <= '0;
            if (accept) begin
                lat_wen         <= req_wen;
                lat_signed      <= req_signed;
                lat_size        <= req_size;
                lat_off         <= req_addr[2:0];
                mem_raddr       <= {req_addr[63:3], 3'b000};
                mem_waddr       <= {req_addr[63:3], 3'b000};
                mem_wdata       <= req_wdata << {req_addr[2:0], 3'b000};
                resp_rdata      <= '0;
                resp_misaligned <= ~req_aligned;
                if (req_aligned) begin
                    mem_read  <= ~req_wen;
                    mem_write <= req_wen;
                    mem_wmask <= req_mask << req_addr[2:0];
                end
            end
            if (state == S_ACCESS) begin
                resp_rdata <= lat_wen ? '0 : load_ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, stall and reset abort.
module tb_mem_access_unit;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_raddr;
    logic [63:0] mem_waddr;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;

    int errors = 0;
    int checks = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then scramble the request inputs
    task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] wdata);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
        req_wen    = ~wen;
        req_size   = ~size;
        req_signed = ~sgn;
        req_addr   = 64'hDEAD_BEEF_DEAD_BEEF;
        req_wdata  = 64'hA5A5_A5A5_A5A5_A5A5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
        checks++; if ({mem_read, mem_write, mem_wmask} !== 10'h0) begin errors++; $display("FAIL rst_strobes: got %b%b %h exp 0", mem_read, mem_write, mem_wmask); end
        checks++; if (mem_raddr !== 64'h0 || mem_wdata !== 64'h0 || resp_rdata !== 64'h0) begin errors++; $display("FAIL rst_data: raddr %h wdata %h rdata %h exp 0", mem_raddr, mem_wdata, resp_rdata); end
        rst = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_load_byte_signed();
        // byte 3 of 0x80FF0000 is 0x80
        mem_rdata  = 64'h0000_0000_80FF_0000;
        resp_ready = 1'b0;
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0);
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL lb_strobe: rd %b wr %b exp 1 0", mem_read, mem_write); end
        checks++; if (mem_raddr !== 64'h8000_0000) begin errors++; $display("FAIL lb_raddr: got %h exp 80000000", mem_raddr); end
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL lb_access_hs: ready %b valid %b exp 0 0", req_ready, resp_valid); end
        step();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL lb_one_strobe: got %b exp 0", mem_read); end
        checks++; if (resp_valid !== 1'b1 || resp_misaligned !== 1'b0) begin errors++; $display("FAIL lb_resp: valid %b mis %b exp 1 0", resp_valid, resp_misaligned); end
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h exp ffffffffffffff80", resp_rdata); end
        resp_ready = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lb_idle: ready %b valid %b exp 1 0", req_ready, resp_valid); end
        // byte 2 holds 0xFF
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0002, 64'h0);
        step();
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL lb2_rdata: got %h exp ffffffffffffffff", resp_rdata); end
        step();
    endtask

    task automatic test_store_half();
        resp_ready = 1'b1;
        issue(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h1234);
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL sh_strobe: wr %b rd %b exp 1 0", mem_write, mem_read); end
        checks++; if (mem_waddr !== 64'h8000_0000) begin errors++; $display("FAIL sh_waddr: got %h exp 80000000", mem_waddr); end
        checks++; if (mem_wmask !== 8'hC0) begin errors++; $display("FAIL sh_wmask: got %h exp c0", mem_wmask); end
        checks++; if (mem_wdata !== 64'h1234_0000_0000_0000) begin errors++; $display("FAIL sh_wdata: got %h exp 1234000000000000", mem_wdata); end
        step();
        checks++; if (mem_write !== 1'b0 || mem_wmask !== 8'h00) begin errors++; $display("FAIL sh_after: wr %b mask %h exp 0 00", mem_write, mem_wmask); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0) begin errors++; $display("FAIL sh_resp: valid %b rdata %h exp 1 0", resp_valid, resp_rdata); end
        checks++; if (mem_wdata !== 64'h1234_0000_0000_0000) begin errors++; $display("FAIL sh_hold: got %h exp 1234000000000000", mem_wdata); end
        step();
        // word store at lane 4 with upper wdata bits shifted out
        issue(1'b1, 2'd2, 1'b0, 64'h0000_0010_0000_0014, 64'hFFFF_FFFF_CAFE_F00D);
        checks++; if (mem_wmask !== 8'hF0 || mem_wdata !== 64'hCAFE_F00D_0000_0000) begin errors++; $display("FAIL sw_lane: mask %h wdata %h exp f0 cafef00d00000000", mem_wmask, mem_wdata); end
        checks++; if (mem_waddr !== 64'h0000_0010_0000_0010) begin errors++; $display("FAIL sw_waddr: got %h exp 0000001000000010", mem_waddr); end
        step();
        step();
    endtask

    task automatic test_misaligned();
        resp_ready = 1'b1;
        mem_rdata  = 64'h1111_2222_3333_4444;
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0);
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL mis_strobe: rd %b wr %b exp 0 0", mem_read, mem_write); end
        checks++; if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1) begin errors++; $display("FAIL mis_resp: valid %b mis %b exp 1 1", resp_valid, resp_misaligned); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL mis_rdata: got %h exp 0", resp_rdata); end
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_idle: got %b exp 1", req_ready); end
        issue(1'b1, 2'd1, 1'b0, 64'h8000_0001, 64'hFFFF);
        checks++; if (mem_write !== 1'b0 || mem_wmask !== 8'h00 || resp_misaligned !== 1'b1) begin errors++; $display("FAIL mis_store: wr %b mask %h mis %b exp 0 00 1", mem_write, mem_wmask, resp_misaligned); end
        step();
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0);
        checks++; if (mem_read !== 1'b0 || resp_misaligned !== 1'b1) begin errors++; $display("FAIL mis_double: rd %b mis %b exp 0 1", mem_read, resp_misaligned); end
        step();
    endtask

    task automatic test_resp_hold();
        resp_ready = 1'b0;
        mem_rdata  = 64'h0123_4567_89AB_CDEF;
        issue(1'b0, 2'd3, 1'b1, 64'h8000_0008, 64'h0);
        checks++; if (mem_read !== 1'b1 || mem_raddr !== 64'h8000_0008) begin errors++; $display("FAIL ld_access: rd %b raddr %h exp 1 80000008", mem_read, mem_raddr); end
        step();
        mem_rdata = 64'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ld_hold%0d: valid %b rdata %h exp 1 0123456789abcdef", i, resp_valid, resp_rdata); end
            checks++; if (req_ready !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL ld_busy%0d: ready %b rd %b exp 0 0", i, req_ready, mem_read); end
            step();
        end
        resp_ready = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL ld_release: ready %b valid %b exp 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_reset_in_access();
        resp_ready = 1'b1;
        mem_rdata  = 64'h0;
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'h0);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL ra_access: got %b exp 1", mem_read); end
        rst = 1'b1;
        step();
        checks++; if (mem_read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ra_abort: rd %b valid %b ready %b exp 0 0 1", mem_read, resp_valid, req_ready); end
        rst = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL ra_quiet: valid %b rd %b exp 0 0", resp_valid, mem_read); end
        // reset while holding a response
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (resp_valid !== 1'b0 || resp_misaligned !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rr_abort: valid %b mis %b ready %b exp 0 0 1", resp_valid, resp_misaligned, req_ready); end
        step();
    endtask

    task automatic test_load_word();
        resp_ready = 1'b1;
        mem_rdata  = 64'h89AB_CDEF_0000_0000;
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0);
        step();
        checks++; if (resp_rdata !== 64'h0000_0000_89AB_CDEF) begin errors++; $display("FAIL lwu_rdata: got %h exp 0000000089abcdef", resp_rdata); end
        step();
        issue(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0);
        step();
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_89AB_CDEF) begin errors++; $display("FAIL lw_rdata: got %h exp ffffffff89abcdef", resp_rdata); end
        step();
        issue(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'h0);
        step();
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_89AB) begin errors++; $display("FAIL lh_rdata: got %h exp ffffffffffff89ab", resp_rdata); end
        step();
        issue(1'b0, 2'd1, 1'b0, 64'h8000_0004, 64'h0);
        step();
        checks++; if (resp_rdata !== 64'h0000_0000_0000_CDEF) begin errors++; $display("FAIL lhu_rdata: got %h exp 000000000000cdef", resp_rdata); end
        step();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 64'h0;
        req_wdata  = 64'h0;
        mem_rdata  = 64'h0;
        resp_ready = 1'b0;
        test_reset();
        test_load_byte_signed();
        test_store_half();
        test_misaligned();
        test_resp_hold();
        test_reset_in_access();
        test_load_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
